pc_fetch_unit: RTL
==================

# pc_fetch_unit

Instruction-fetch stage of the RV32 core: holds the program counter, issues one instruction-memory request at a time over a valid/ready handshake, and presents fetched instructions to decode. It sits directly downstream of the branch-condition unit. When execute resolves a taken branch or jump, this block redirects the PC, discards stale fetches, and flushes younger stages.

## Interface
- RESET_PC, default 32'h0000_0000: PC after reset. Bits [1:0] must be 0.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ex_valid  in  1  execute stage holds a valid instruction.
- br_taken  in  1  branch condition met (from branch-condition unit).
- jump  in  1  unconditional jump (jal/jalr) in execute.
- br_target  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- stall  in  1  decode cannot accept; hold the output.
- imem_req_valid  out  1  request to instruction memory.
- imem_req_addr  out  32  request word address.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  response data valid. At most one response per accepted request.
- imem_rsp_data  in  32  fetched instruction.
- if_valid  out  1  if_pc/if_instr hold a valid instruction.
- if_pc  out  32  PC of the presented instruction.
- if_instr  out  32  presented instruction.
- flush  out  1  kill IF/ID and ID/EX this cycle.

## Operation
- Redirect: redirect = ex_valid & (br_taken | jump). It has the highest priority and overrides stall.
- flush = redirect, combinational, same cycle.
- State machine: IDLE, REQ, WAIT, HOLD. Registers:
  - pc: next fetch address.
  - req_pc: address of the outstanding request.
  - drop: the outstanding response is stale.
  - skid: one-entry {pc, instr} buffer.
- IDLE
  - Entered on reset.
  - Moves to REQ on the first edge with rst_n=1.
- REQ
  - imem_req_valid=1, imem_req_addr=pc.
  - Once asserted, valid and addr stay stable until ready, even across a redirect.
  - On ready: req_pc<=pc, pc<=pc+4, go to WAIT.
- WAIT. On imem_rsp_valid:
  - If drop=1: discard the response, clear drop, go to REQ.
  - Else if the output is free (!if_valid | !stall): load if_pc<=req_pc, if_instr<=data, if_valid<=1, go to REQ.
  - Else: load skid, go to HOLD.
- HOLD
  - When stall=0: move skid to the output, go to REQ.
- Output register
  - Cleared (if_valid<=0) when !stall and no new instruction is loaded.
  - Held unchanged while stall=1.
- Redirect, applied in the same cycle:
  - pc <= {br_target[31:2],2'b00}.
  - if_valid<=0; skid is discarded.
  - REQ without ready: stay in REQ with the old addr, set drop; the request completes later and its response is dropped. Then fetch from the new pc.
  - REQ with ready: go to WAIT with drop=1. pc gets the target, not pc+4.
  - WAIT without a response: set drop.
  - WAIT with a response in the same cycle: discard it, go to REQ.
  - HOLD: go to REQ.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.

## Timing
- Reset values (rst_n=0 at an edge):
  - state=IDLE, pc=RESET_PC, req_pc=0, drop=0, skid empty.
  - imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0.
  - flush=0 unless redirect is asserted.
- Reset mid-operation takes effect at that edge: outstanding request state is lost and any later response is ignored until the next accepted request.
- First request: imem_req_valid rises one cycle after the first edge with rst_n=1.
- Latency: request accept at edge N, response in cycle N+k, if_valid=1 from edge N+k.
- Throughput: with zero-wait memory (ready=1, response in the next cycle), one instruction every 2 cycles.
- At most one request is outstanding; no new request is issued in WAIT or HOLD.
- Redirect to first target request: imem_req_valid is asserted for the target the cycle after the stale response is dropped, or the cycle after the redirect when nothing is outstanding.

## Test plan
- Reset and sequential fetch.
  - Stimulus: RESET_PC=0, ready=1, response in the next cycle.
  - Required: request addresses 0, 4, 8; if_pc 0/4/8 with the matching data; if_valid pulses every 2nd cycle.
- Redirect during WAIT.
  - Stimulus: redirect to 0x100 while the fetch of 0x8 is outstanding.
  - Required: flush=1 for one cycle; the 0x8 response is dropped (if_valid stays 0); next request addr=0x100; if_pc=0x100.
- Stall with skid.
  - Stimulus: hold stall=1 for 5 cycles while the instruction at 0x4 is presented.
  - Required: the next fetch (0x8) goes into skid; if_pc stays 0x4; after release, if_pc=0x8 next cycle with no lost or duplicated instruction.
- Redirect coincident with a response, and with a pending unaccepted request.
  - Stimulus: redirect in the same cycle as rsp_valid; separately, redirect while ready=0.
  - Required: the first response is discarded; for the pending request the addr stays stable, its response is dropped, then the target is fetched; br_target=0x203 yields a fetch at 0x200.
- Wrap-around.
  - Stimulus: RESET_PC=32'hFFFF_FFFC.
  - Required: second request addr=0.
- Reset mid-operation.
  - Stimulus: rst_n=0 in WAIT with a late response arriving during reset.
  - Required: if_valid=0; the first request after reset is at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: RV32 instruction-fetch stage.
// Owns the PC, fetches one word at a time, handles redirects.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        br_taken,
  input  logic        jump,
  input  logic [31:0] br_target,
  input  logic        stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        flush
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        drop_q, drop_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        redirect;
  logic        out_free;
  logic [31:0] tgt;

  assign redirect = ex_valid & (br_taken | jump);
  assign tgt      = br_target & ~32'd3;
  assign flush    = redirect;
  assign out_free = !if_valid_q || !stall;

  assign imem_req_valid = (state_q == REQ);
  // A redirect hitting an unaccepted request parks
  // that request's address in req_pc until accepted.
  assign imem_req_addr  = (state_q == REQ && drop_q) ?
                          req_pc_q : pc_q;

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;

  // Next-state, PC and output-register update.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    drop_d       = drop_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    if (!stall) if_valid_d = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_req_ready) begin
          state_d = WAIT;
          if (!drop_q) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
          end
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_d = REQ;
          drop_d  = 1'b0;
          if (!drop_q) begin
            if (out_free) begin
              if_valid_d = 1'b1;
              if_pc_d    = req_pc_q;
              if_instr_d = imem_rsp_data;
            end else begin
              skid_pc_d    = req_pc_q;
              skid_instr_d = imem_rsp_data;
              state_d      = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          if_valid_d = 1'b1;
          if_pc_d    = skid_pc_q;
          if_instr_d = skid_instr_q;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect) begin
      pc_d       = tgt;
      if_valid_d = 1'b0;
      case (state_q)
        REQ: begin
          drop_d = 1'b1;
          if (!imem_req_ready && !drop_q)
            req_pc_d = pc_q;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            state_d = REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d = 1'b1;
          end
        end
        HOLD:    state_d = REQ;
        default: state_d = REQ;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_pc_q     <= 32'd0;
      drop_q       <= 1'b0;
      skid_pc_q    <= 32'd0;
      skid_instr_q <= 32'd0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= 32'd0;
      if_instr_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      drop_q       <= drop_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
    end
  end

endmodule
